div_clk_monitor: RTL and testbench

- Sits directly downstream of the odd-ratio clock dividers (default ÷15) and checks the divided clock against the source clock.
- Samples the divided clock in the source clock domain and measures its period and high time in source-clock cycles.
- Declares lock after N consecutive in-tolerance periods and raises a sticky error on loss.
- Used as a bring-up/self-test checker on every divider instance.

---
 rtl/div_clk_monitor.sv | 129 ++++++++++++
 tb/tb_div_clk_monitor.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/div_clk_monitor.sv
// Frequency/duty checker for a divided clock: measures period and high time
// in source-clock cycles, tracks lock over consecutive good periods, flags loss.
module div_clk_monitor #(
    parameter int EXP_PERIOD = 15,
    parameter int TOL        = 1,
    parameter int LOCK_COUNT = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_clk,
    input  logic             clr_err,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             err
);

    localparam int GC_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(EXP_PERIOD + TOL);
    localparam logic [GC_W-1:0]  GC_ONE  = 1;
    localparam logic [GC_W-1:0]  GC_LAST = GC_W'(LOCK_COUNT - 1);
    localparam logic [GC_W-1:0]  GC_FULL = GC_W'(LOCK_COUNT);

    typedef enum logic [1:0] {ACQUIRE, LOCKED, LOST} state_t;

    state_t           state;
    logic [GC_W-1:0]  good_cnt;
    logic             s1, s2, s, p;
    logic             rise, fall, timeout, good, first_seen;
    logic [CNT_W-1:0] cnt, hcnt, meas;

    assign s    = s2;
    assign rise = s & ~p;
    assign fall = ~s & p;

    // Value captured on rise; a saturated counter stays at all-ones so it can never look good.
    assign meas    = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;
    assign timeout = (cnt == TMO_VAL) && !rise;
    assign locked  = (state == LOCKED);

    always_comb begin
        good = 1'b0;
        if (cnt != CNT_MAX && int'(meas) >= EXP_PERIOD - TOL && int'(meas) <= EXP_PERIOD + TOL)
            good = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            p          <= 1'b0;
            cnt        <= '0;
            hcnt       <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            first_seen <= 1'b0;
            good_cnt   <= '0;
            err        <= 1'b0;
            state      <= ACQUIRE;
        end else begin
            s1         <= div_clk;
            s2         <= s1;
            p          <= s2;
            meas_valid <= 1'b0;

            if (rise)                cnt <= '0;
            else if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;

            if (rise)                        hcnt <= CNT_ONE;
            else if (s && hcnt != CNT_MAX)   hcnt <= hcnt + CNT_ONE;

            if (rise) begin
                first_seen <= 1'b1;
                if (first_seen) begin
                    period     <= meas;
                    meas_valid <= 1'b1;
                end
            end

            // first_seen doubles as "a rise has been seen since reset"
            if (fall && first_seen) high_time <= hcnt;

            // Set inside the FSM below overrides this clear when both happen together.
            if (clr_err) err <= 1'b0;

            case (state)
                ACQUIRE: begin
                    if (rise && first_seen) begin
                        if (good) begin
                            if (good_cnt == GC_LAST) begin
                                good_cnt <= GC_FULL;
                                state    <= LOCKED;
                            end else begin
                                good_cnt <= good_cnt + GC_ONE;
                            end
                        end else begin
                            good_cnt <= '0;
                        end
                    end else if (timeout) begin
                        good_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if ((rise && first_seen && !good) || timeout) begin
                        state    <= LOST;
                        err      <= 1'b1;
                        good_cnt <= '0;
                    end
                end
                LOST: begin
                    if (rise && first_seen && good) begin
                        good_cnt <= GC_ONE;
                        state    <= (LOCK_COUNT == 1) ? LOCKED : ACQUIRE;
                    end
                end
                default: begin
                    state    <= ACQUIRE;
                    good_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_clk_monitor.sv
// Bench for div_clk_monitor: segment table drives div_clk, measurements are
// checked through a scoreboard queue, lock/err checked at each segment end.
module tb_div_clk_monitor;

    logic       clk = 1'b0, rst = 1'b1, rst_b = 1'b1, div_clk = 1'b0, clr_err = 1'b0;
    logic [7:0] period_a, high_a, period_b, high_b;
    logic       mv_a, lk_a, err_a, mv_b, lk_b, err_b;

    div_clk_monitor u_a (
        .clk(clk), .rst(rst), .div_clk(div_clk), .clr_err(clr_err),
        .period(period_a), .high_time(high_a), .meas_valid(mv_a),
        .locked(lk_a), .err(err_a)
    );

    div_clk_monitor #(.TOL(0), .LOCK_COUNT(1)) u_b (
        .clk(clk), .rst(rst_b), .div_clk(div_clk), .clr_err(clr_err),
        .period(period_b), .high_time(high_b), .meas_valid(mv_b),
        .locked(lk_b), .err(err_b)
    );

    always #5 clk = ~clk;

    typedef struct { int pl; int hi; } meas_t;
    // clr: 0 none, 1 aligned with the rise-processing edge, 2 mid low phase
    // pre: before this segment, reset unit a mid-run (unit 0) or release unit b (unit 1)
    typedef struct { int h; int l; int clr; bit pre; bit unit; bit exp_lk; bit exp_err; } vec_t;

    meas_t q[$];
    vec_t  tbl[$];
    meas_t prev;
    bit    have_prev = 1'b0;
    int    n_cmp = 0, n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input int h, input int l, input int clr, input bit pre,
                       input bit unit, input bit lk, input bit er);
        vec_t v;
        v.h = h; v.l = l; v.clr = clr; v.pre = pre; v.unit = unit; v.exp_lk = lk; v.exp_err = er;
        tbl.push_back(v);
    endtask

    // Each new rise closes the previous segment, so that is when its result is expected.
    task automatic seg(input int h, input int l, input int clr);
        if (have_prev) q.push_back(prev);
        prev.pl = h + l; prev.hi = h; have_prev = 1'b1;
        div_clk = 1'b1;
        for (int c = 1; c <= h + l; c++) begin
            @(negedge clk);
            if (c == h) div_clk = 1'b0;
            if (clr == 1 && c == 2) clr_err = 1'b1;
            if (clr == 1 && c == 3) clr_err = 1'b0;
            if (clr == 2 && c == h + 4) clr_err = 1'b1;
            if (clr == 2 && c == h + 5) clr_err = 1'b0;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_period"}, period_a, 0);
        check({tag, "_high"}, high_a, 0);
        check({tag, "_mv"}, mv_a, 0);
        check({tag, "_locked"}, lk_a, 0);
        check({tag, "_err"}, err_a, 0);
    endtask

    always @(negedge clk) begin
        meas_t m;
        if (mv_a) begin
            if (q.size() == 0) begin
                check("meas_unexpected", 1, 0);
            end else begin
                m = q.pop_front();
                check("period", period_a, m.pl);
                check("high_time", high_a, m.hi);
            end
        end
    end

    initial begin
        // unit a: lock, tolerance edges, loss, relock
        add(8, 7, 0, 0, 0, 0, 0);   // first rise discarded
        add(8, 7, 0, 0, 0, 0, 0);
        add(8, 7, 0, 0, 0, 0, 0);
        add(8, 7, 0, 0, 0, 0, 0);
        add(8, 7, 0, 0, 0, 1, 0);   // 5th rise -> locked
        add(8, 8, 0, 0, 0, 1, 0);   // period 16
        add(7, 7, 0, 0, 0, 1, 0);   // period 14
        add(8, 9, 0, 0, 0, 1, 0);   // period 17
        add(8, 7, 0, 0, 0, 0, 1);   // 17 captured -> LOST
        add(8, 7, 0, 0, 0, 0, 1);
        add(8, 7, 0, 0, 0, 0, 1);
        add(8, 7, 0, 0, 0, 0, 1);
        add(8, 7, 0, 0, 0, 1, 1);   // relocked, err sticky
        add(8, 30, 0, 0, 0, 0, 1);  // held low -> timeout
        add(8, 7, 2, 0, 0, 0, 0);   // clr_err alone clears
        add(8, 7, 0, 0, 0, 0, 0);
        add(8, 7, 0, 0, 0, 0, 0);
        add(8, 7, 0, 0, 0, 0, 0);
        add(8, 7, 0, 0, 0, 1, 0);
        add(8, 9, 0, 0, 0, 1, 0);   // period 17 follows
        add(8, 7, 1, 0, 0, 0, 1);   // bad rise + clr_err same edge: set wins
        add(8, 7, 2, 0, 0, 0, 0);
        add(8, 7, 0, 0, 0, 0, 0);
        add(8, 7, 0, 0, 0, 0, 0);
        add(8, 7, 0, 0, 0, 1, 0);
        add(8, 7, 0, 1, 0, 0, 0);   // reset mid-LOCKED, first rise discarded
        add(8, 7, 0, 0, 0, 0, 0);
        add(8, 7, 0, 0, 0, 0, 0);
        add(8, 7, 0, 0, 0, 0, 0);
        add(8, 7, 0, 0, 0, 1, 0);   // relock after 5 rises
        // unit b: TOL=0, LOCK_COUNT=1, alternating 15/16
        add(8, 7, 0, 1, 1, 0, 0);
        add(8, 7, 0, 0, 1, 1, 0);
        add(8, 8, 0, 0, 1, 1, 0);
        add(8, 7, 0, 0, 1, 0, 1);
        add(8, 8, 0, 0, 1, 1, 1);
        add(8, 7, 0, 0, 1, 0, 1);
        add(8, 7, 0, 0, 1, 1, 1);

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].pre && !tbl[i].unit) begin
                rst = 1'b1;
                @(negedge clk);
                check_zero("midreset");
                rst = 1'b0;
                q.delete();
                have_prev = 1'b0;
            end
            if (tbl[i].pre && tbl[i].unit) rst_b = 1'b0;
            seg(tbl[i].h, tbl[i].l, tbl[i].clr);
            if (!tbl[i].unit) begin
                check($sformatf("a_locked_seg%0d", i), lk_a, tbl[i].exp_lk);
                check($sformatf("a_err_seg%0d", i), err_a, tbl[i].exp_err);
            end else begin
                check($sformatf("b_locked_seg%0d", i), lk_b, tbl[i].exp_lk);
                check($sformatf("b_err_seg%0d", i), err_b, tbl[i].exp_err);
            end
        end

        repeat (5) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
